reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- Circular in-order commit buffer for the Tomasulo core.
- Allocates ROB ids to the dispatcher and captures results broadcast on the RS and LS CDBs.
- Answers operand-readiness queries from the dispatcher, which the dispatcher turns into V/Q fields.
- Commits one instruction per cycle in program order to the register file and LSB. On a mispredicted branch it raises commit_jump_flag, which flushes the RS, LSB and itself.

Parameters:
- ROB_SIZE, 15: usable entries. Ids run 1..15; id 0 (ZERO_ROB) means "no dependency" and is never allocated.
- ID_W, 4: ROB id width.
- DATA_W, 32: data/address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rdy  in  1  global ready; when low, all state holds.
- ena_from_dsp  in  1  allocate request.
- rd_from_dsp  in  5  destination register (0 = none).
- is_store_from_dsp  in  1  entry is a store.
- pc_from_dsp  in  DATA_W  instruction pc.
- rob_id_to_dsp  out  ID_W  id that an allocation this cycle receives (= tail), combinational.
- full_to_if  out  1  no free entry, combinational from count.
- Q1_query, Q2_query  in  ID_W  operand ids to resolve.
- Q1_ready, Q2_ready  out  1  value available.
- V1_query, V2_query  out  DATA_W  value when ready.
- valid_from_rs_cdb, rob_id_from_rs_cdb, result_from_rs_cdb  in  1/ID_W/DATA_W  ALU broadcast.
- mispredict_from_rs_cdb  in  1  branch resolved against its prediction.
- target_pc_from_rs_cdb  in  DATA_W  correct next pc.
- valid_from_ls_cdb, rob_id_from_ls_cdb, result_from_ls_cdb  in  1/ID_W/DATA_W  LSB broadcast.
- commit_valid_to_reg  out  1  register write this cycle.
- commit_rd_to_reg  out  5  destination register.
- commit_value_to_reg  out  DATA_W  value written.
- commit_rob_id  out  ID_W  id committed; used by the register file to clear its tag and by the LSB.
- commit_store_to_lsb  out  1  head store may execute.
- commit_jump_flag  out  1  flush pulse.
- target_pc_to_if  out  DATA_W  redirect pc.

Behaviour:
- Per-entry state: busy, ready, rd, is_store, mispredict, value, target_pc. Pointers head, tail in 1..15; count 0..15.
- Reset (async): all entries not busy; head = tail = 1; count = 0; every registered output = 0.
- Pointer wrap: 15 -> 1; id 0 is skipped.
- full_to_if = (count == ROB_SIZE). An allocation is accepted only when ena_from_dsp && !full_to_if. The entry written at tail gets busy=1, ready=0, and tail advances.
- CDB capture: a valid RS or LS CDB write to a busy entry sets ready=1 and value. The RS CDB also latches mispredict and target_pc. Both CDBs may write different ids in the same cycle. A CDB write to a non-busy id is ignored.
- Query (combinational), evaluated per port:
  - Id 0: ready=1, V=0.
  - Else if an entry with that id is busy and ready: its value.
  - Else if the id matches this cycle's RS CDB: that result, with RS CDB taking priority over LS CDB.
  - Else if it matches this cycle's LS CDB: that result.
  - Otherwise ready=0.
- Commit: when head is busy and ready, the entry commits at the edge. Outputs are registered and held for one cycle:
  - commit_valid_to_reg = (rd != 0 && !is_store).
  - commit_store_to_lsb = is_store.
  - head advances.
  - Otherwise all commit strobes are 0 on that cycle.
- Mispredict commit: same register write (JAL/JALR link) plus commit_jump_flag=1 and target_pc_to_if for exactly one cycle.
  - While commit_jump_flag is high, the next edge clears every entry, sets head=tail=1 and count=0, and ignores dispatch, CDB and commit.
  - Downstream units flush on the same edge.
- Simultaneous allocation and commit: count unchanged. Full is judged on the pre-edge count, so an allocation in a full cycle is refused even if commit frees a slot.
- A commit is reflected by count-1 on the next cycle.
- rdy=0: nothing changes; commit strobes are held at 0.

Test Plan:
1. After reset, allocate three entries (rd=5,6,7) -> rob_id_to_dsp returns 1, 2, 3; count=3; full_to_if=0.
2. Send CDB results out of order (id 3 = 0x30, id 1 = 0x10, id 2 = 0x20) -> commits occur in order 1, 2, 3 with values 0x10, 0x20, 0x30 on consecutive cycles once head is ready.
3. Allocate 15 entries -> full_to_if=1 and a 16th request is refused. Commit id 1 while requesting -> still refused that cycle. The next allocation gets id 1 (wrap).
4. Query id 4 while the RS CDB broadcasts id 4 = 0xAB in the same cycle -> Q1_ready=1, V1_query=0xAB. Query id 0 -> ready=1.
5. Branch at id 2 with mispredict=1 and target 0x1000 -> at its commit, commit_jump_flag=1 and target_pc_to_if=0x1000 for one cycle. Next cycle count=0, rob_id_to_dsp=1, and the entry at id 3 is never committed.
6. Assert rst asynchronously mid-commit -> all outputs 0 immediately; head=tail=1.

Source files
------------

// File: rtl/reorder_buffer_if.sv
// Dispatcher, CDB and commit signals of the reorder buffer.
// The slave modport is the ROB itself; the master modport is whatever surrounds it.
interface reorder_buffer_if #(
    parameter int ID_W   = 4,
    parameter int DATA_W = 32
);
    // dispatch / allocation
    logic              ena_from_dsp;
    logic [4:0]        rd_from_dsp;
    logic              is_store_from_dsp;
    logic [DATA_W-1:0] pc_from_dsp;
    logic [ID_W-1:0]   rob_id_to_dsp;
    logic              full_to_if;

    // operand queries
    logic [ID_W-1:0]   Q1_query;
    logic [ID_W-1:0]   Q2_query;
    logic              Q1_ready;
    logic              Q2_ready;
    logic [DATA_W-1:0] V1_query;
    logic [DATA_W-1:0] V2_query;

    // result broadcasts
    logic              valid_from_rs_cdb;
    logic [ID_W-1:0]   rob_id_from_rs_cdb;
    logic [DATA_W-1:0] result_from_rs_cdb;
    logic              mispredict_from_rs_cdb;
    logic [DATA_W-1:0] target_pc_from_rs_cdb;
    logic              valid_from_ls_cdb;
    logic [ID_W-1:0]   rob_id_from_ls_cdb;
    logic [DATA_W-1:0] result_from_ls_cdb;

    // commit
    logic              commit_valid_to_reg;
    logic [4:0]        commit_rd_to_reg;
    logic [DATA_W-1:0] commit_value_to_reg;
    logic [ID_W-1:0]   commit_rob_id;
    logic              commit_store_to_lsb;
    logic              commit_jump_flag;
    logic [DATA_W-1:0] target_pc_to_if;

    modport slave (
        input  ena_from_dsp, rd_from_dsp, is_store_from_dsp, pc_from_dsp,
        output rob_id_to_dsp, full_to_if,
        input  Q1_query, Q2_query,
        output Q1_ready, Q2_ready, V1_query, V2_query,
        input  valid_from_rs_cdb, rob_id_from_rs_cdb, result_from_rs_cdb,
        input  mispredict_from_rs_cdb, target_pc_from_rs_cdb,
        input  valid_from_ls_cdb, rob_id_from_ls_cdb, result_from_ls_cdb,
        output commit_valid_to_reg, commit_rd_to_reg, commit_value_to_reg,
        output commit_rob_id, commit_store_to_lsb, commit_jump_flag, target_pc_to_if
    );

    modport master (
        output ena_from_dsp, rd_from_dsp, is_store_from_dsp, pc_from_dsp,
        input  rob_id_to_dsp, full_to_if,
        output Q1_query, Q2_query,
        input  Q1_ready, Q2_ready, V1_query, V2_query,
        output valid_from_rs_cdb, rob_id_from_rs_cdb, result_from_rs_cdb,
        output mispredict_from_rs_cdb, target_pc_from_rs_cdb,
        output valid_from_ls_cdb, rob_id_from_ls_cdb, result_from_ls_cdb,
        input  commit_valid_to_reg, commit_rd_to_reg, commit_value_to_reg,
        input  commit_rob_id, commit_store_to_lsb, commit_jump_flag, target_pc_to_if
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order commit buffer: allocates ids 1..ROB_SIZE, captures CDB results,
// answers operand queries and retires one entry per cycle, flushing on a mispredict.
module reorder_buffer #(
    parameter int ROB_SIZE = 15,
    parameter int ID_W     = 4,
    parameter int DATA_W   = 32
) (
    input logic            clk,
    input logic            rst,
    input logic            rdy,
    reorder_buffer_if.slave bus
);
    // Slot 0 is ZERO_ROB and is never allocated, so storage has one spare entry.
    localparam int DEPTH = ROB_SIZE + 1;
    localparam int CNT_W = $clog2(ROB_SIZE + 1);
    localparam logic [ID_W-1:0] FIRST_ID = ID_W'(1);
    localparam logic [ID_W-1:0] LAST_ID  = ID_W'(ROB_SIZE);

    typedef struct packed {
        logic              ready;
        logic [DATA_W-1:0] value;
    } query_t;

    // entry flags (reset) and payload (not reset)
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [DEPTH-1:0]  ready_q, ready_d;
    logic [DEPTH-1:0]  store_q, store_d;
    logic [DEPTH-1:0]  mispredict_q, mispredict_d;
    logic [4:0]        rd_q     [DEPTH];
    logic [4:0]        rd_d     [DEPTH];
    logic [DATA_W-1:0] value_q  [DEPTH];
    logic [DATA_W-1:0] value_d  [DEPTH];
    logic [DATA_W-1:0] target_q [DEPTH];
    logic [DATA_W-1:0] target_d [DEPTH];

    logic [ID_W-1:0]   head_q, head_d;
    logic [ID_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // registered commit outputs
    logic              commit_valid_q, commit_valid_d;
    logic [4:0]        commit_rd_q, commit_rd_d;
    logic [DATA_W-1:0] commit_value_q, commit_value_d;
    logic [ID_W-1:0]   commit_rob_id_q, commit_rob_id_d;
    logic              commit_store_q, commit_store_d;
    logic              jump_q, jump_d;
    logic [DATA_W-1:0] jump_target_q, jump_target_d;

    logic              full;
    logic              do_alloc;
    logic              do_commit;
    query_t            q1_res;
    query_t            q2_res;

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (id == LAST_ID) ? FIRST_ID : id + FIRST_ID;
    endfunction

    // Stored value first, then same-cycle broadcasts with RS ahead of LS.
    function automatic query_t lookup(input logic [ID_W-1:0] id);
        query_t res;
        res = '0;
        if (id == '0) begin
            res.ready = 1'b1;
        end else if (busy_q[id] && ready_q[id]) begin
            res.ready = 1'b1;
            res.value = value_q[id];
        end else if (bus.valid_from_rs_cdb && bus.rob_id_from_rs_cdb == id) begin
            res.ready = 1'b1;
            res.value = bus.result_from_rs_cdb;
        end else if (bus.valid_from_ls_cdb && bus.rob_id_from_ls_cdb == id) begin
            res.ready = 1'b1;
            res.value = bus.result_from_ls_cdb;
        end
        return res;
    endfunction

    assign full = (count_q == CNT_W'(ROB_SIZE));

    // NOTE: every always_comb output gets a default up front, otherwise a path that
    // skips an assignment would infer a latch.
    always_comb begin
        busy_d          = busy_q;
        ready_d         = ready_q;
        store_d         = store_q;
        mispredict_d    = mispredict_q;
        rd_d            = rd_q;
        value_d         = value_q;
        target_d        = target_q;
        head_d          = head_q;
        tail_d          = tail_q;
        count_d         = count_q;
        commit_valid_d  = 1'b0;
        commit_rd_d     = '0;
        commit_value_d  = '0;
        commit_rob_id_d = '0;
        commit_store_d  = 1'b0;
        jump_d          = 1'b0;
        jump_target_d   = '0;
        do_alloc        = 1'b0;
        do_commit       = 1'b0;

        // The flush edge must not be lost to a stalled rdy: downstream flushes on it too.
        if (jump_q) begin
            busy_d  = '0;
            ready_d = '0;
            head_d  = FIRST_ID;
            tail_d  = FIRST_ID;
            count_d = '0;
        end else if (rdy) begin
            if (bus.valid_from_rs_cdb && busy_q[bus.rob_id_from_rs_cdb]) begin
                ready_d[bus.rob_id_from_rs_cdb]      = 1'b1;
                value_d[bus.rob_id_from_rs_cdb]      = bus.result_from_rs_cdb;
                mispredict_d[bus.rob_id_from_rs_cdb] = bus.mispredict_from_rs_cdb;
                target_d[bus.rob_id_from_rs_cdb]     = bus.target_pc_from_rs_cdb;
            end
            if (bus.valid_from_ls_cdb && busy_q[bus.rob_id_from_ls_cdb]) begin
                ready_d[bus.rob_id_from_ls_cdb] = 1'b1;
                value_d[bus.rob_id_from_ls_cdb] = bus.result_from_ls_cdb;
            end

            do_commit = busy_q[head_q] && ready_q[head_q];
            do_alloc  = bus.ena_from_dsp && !full;

            if (do_commit) begin
                commit_valid_d  = (rd_q[head_q] != 5'd0) && !store_q[head_q];
                commit_rd_d     = rd_q[head_q];
                commit_value_d  = value_q[head_q];
                commit_rob_id_d = head_q;
                commit_store_d  = store_q[head_q];
                jump_d          = mispredict_q[head_q];
                jump_target_d   = mispredict_q[head_q] ? target_q[head_q] : '0;
                busy_d[head_q]  = 1'b0;
                ready_d[head_q] = 1'b0;
                head_d          = next_id(head_q);
            end

            // tail is never head while an entry is live there, so this cannot clobber a commit
            if (do_alloc) begin
                busy_d[tail_q]       = 1'b1;
                ready_d[tail_q]      = 1'b0;
                store_d[tail_q]      = bus.is_store_from_dsp;
                mispredict_d[tail_q] = 1'b0;
                rd_d[tail_q]         = bus.rd_from_dsp;
                tail_d               = next_id(tail_q);
            end

            count_d = count_q + CNT_W'(do_alloc) - CNT_W'(do_commit);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q          <= '0;
            ready_q         <= '0;
            store_q         <= '0;
            mispredict_q    <= '0;
            head_q          <= FIRST_ID;
            tail_q          <= FIRST_ID;
            count_q         <= '0;
            commit_valid_q  <= 1'b0;
            commit_rd_q     <= '0;
            commit_value_q  <= '0;
            commit_rob_id_q <= '0;
            commit_store_q  <= 1'b0;
            jump_q          <= 1'b0;
            jump_target_q   <= '0;
        end else begin
            busy_q          <= busy_d;
            ready_q         <= ready_d;
            store_q         <= store_d;
            mispredict_q    <= mispredict_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            commit_valid_q  <= commit_valid_d;
            commit_rd_q     <= commit_rd_d;
            commit_value_q  <= commit_value_d;
            commit_rob_id_q <= commit_rob_id_d;
            commit_store_q  <= commit_store_d;
            jump_q          <= jump_d;
            jump_target_q   <= jump_target_d;
        end
    end

    // NOTE: payload arrays carry no reset; busy/ready gate every read, so their
    // power-up contents are never observed and they map onto plain storage.
    always_ff @(posedge clk) begin
        rd_q     <= rd_d;
        value_q  <= value_d;
        target_q <= target_d;
    end

    always_comb begin
        q1_res = lookup(bus.Q1_query);
        q2_res = lookup(bus.Q2_query);
    end

    assign bus.Q1_ready = q1_res.ready;
    assign bus.V1_query = q1_res.value;
    assign bus.Q2_ready = q2_res.ready;
    assign bus.V2_query = q2_res.value;

    assign bus.rob_id_to_dsp       = tail_q;
    assign bus.full_to_if          = full;
    assign bus.commit_valid_to_reg = commit_valid_q;
    assign bus.commit_rd_to_reg    = commit_rd_q;
    assign bus.commit_value_to_reg = commit_value_q;
    assign bus.commit_rob_id       = commit_rob_id_q;
    assign bus.commit_store_to_lsb = commit_store_q;
    assign bus.commit_jump_flag    = jump_q;
    assign bus.target_pc_to_if     = jump_target_q;

    // The dispatch pc travels with the request but retirement never needs it.
    logic unused_pc;
    assign unused_pc = ^bus.pc_from_dsp;
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: allocation, in-order commit, wrap/full,
// query bypass, mispredict flush, rdy stall and asynchronous reset.
module tb_reorder_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    int   total = 0;
    int   bad   = 0;

    reorder_buffer_if #(.ID_W(4), .DATA_W(32)) bus ();

    reorder_buffer #(.ROB_SIZE(15), .ID_W(4), .DATA_W(32)) dut (
        .clk(clk),
        .rst(rst),
        .rdy(rdy),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.ena_from_dsp           = 1'b0;
        bus.rd_from_dsp            = 5'd0;
        bus.is_store_from_dsp      = 1'b0;
        bus.pc_from_dsp            = 32'd0;
        bus.Q1_query               = 4'd0;
        bus.Q2_query               = 4'd0;
        bus.valid_from_rs_cdb      = 1'b0;
        bus.rob_id_from_rs_cdb     = 4'd0;
        bus.result_from_rs_cdb     = 32'd0;
        bus.mispredict_from_rs_cdb = 1'b0;
        bus.target_pc_from_rs_cdb  = 32'd0;
        bus.valid_from_ls_cdb      = 1'b0;
        bus.rob_id_from_ls_cdb     = 4'd0;
        bus.result_from_ls_cdb     = 32'd0;
    endtask

    task automatic do_reset();
        idle();
        rdy = 1'b1;
        rst = 1'b1;
        #2;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic alloc(input logic [4:0] rd, input logic st);
        bus.ena_from_dsp      = 1'b1;
        bus.rd_from_dsp       = rd;
        bus.is_store_from_dsp = st;
        bus.pc_from_dsp       = {27'd0, rd} << 2;
        tick();
        bus.ena_from_dsp      = 1'b0;
    endtask

    task automatic rs_cdb(input logic [3:0] id, input logic [31:0] val);
        bus.valid_from_rs_cdb  = 1'b1;
        bus.rob_id_from_rs_cdb = id;
        bus.result_from_rs_cdb = val;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.rob_id_to_dsp !== 4'd1) begin bad++; $display("FAIL reset_rob_id got=%0h exp=1", bus.rob_id_to_dsp); end
        total++; if (bus.full_to_if !== 1'b0) begin bad++; $display("FAIL reset_full got=%0b exp=0", bus.full_to_if); end
        total++; if ({bus.commit_valid_to_reg, bus.commit_store_to_lsb, bus.commit_jump_flag} !== 3'b000) begin bad++; $display("FAIL reset_strobes got=%03b exp=000", {bus.commit_valid_to_reg, bus.commit_store_to_lsb, bus.commit_jump_flag}); end
        total++; if ({bus.commit_rd_to_reg, bus.commit_value_to_reg, bus.commit_rob_id, bus.target_pc_to_if} !== '0) begin bad++; $display("FAIL reset_data got rd=%0h val=%0h id=%0h tgt=%0h exp=0", bus.commit_rd_to_reg, bus.commit_value_to_reg, bus.commit_rob_id, bus.target_pc_to_if); end
    endtask

    task automatic test_alloc();
        for (int i = 0; i < 3; i++) begin
            total++; if (bus.rob_id_to_dsp !== 4'(i + 1)) begin bad++; $display("FAIL alloc_id got=%0h exp=%0h", bus.rob_id_to_dsp, i + 1); end
            alloc(5'(5 + i), 1'b0);
        end
        total++; if (bus.rob_id_to_dsp !== 4'd4) begin bad++; $display("FAIL alloc_tail got=%0h exp=4", bus.rob_id_to_dsp); end
        total++; if (bus.full_to_if !== 1'b0) begin bad++; $display("FAIL alloc_full got=%0b exp=0", bus.full_to_if); end
    endtask

    task automatic test_in_order_commit();
        rs_cdb(4'd3, 32'h30);
        tick();
        total++; if (bus.commit_valid_to_reg !== 1'b0) begin bad++; $display("FAIL order_no_commit3 got=%0b exp=0", bus.commit_valid_to_reg); end
        rs_cdb(4'd1, 32'h10);
        tick();
        total++; if (bus.commit_valid_to_reg !== 1'b0) begin bad++; $display("FAIL order_no_commit1 got=%0b exp=0", bus.commit_valid_to_reg); end
        bus.valid_from_rs_cdb  = 1'b0;
        bus.valid_from_ls_cdb  = 1'b1;
        bus.rob_id_from_ls_cdb = 4'd2;
        bus.result_from_ls_cdb = 32'h20;
        tick();
        bus.valid_from_ls_cdb  = 1'b0;
        total++; if ({bus.commit_valid_to_reg, bus.commit_rd_to_reg, bus.commit_rob_id, bus.commit_value_to_reg} !== {1'b1, 5'd5, 4'd1, 32'h10}) begin bad++; $display("FAIL order_c1 got v=%0b rd=%0d id=%0d val=%0h exp v=1 rd=5 id=1 val=10", bus.commit_valid_to_reg, bus.commit_rd_to_reg, bus.commit_rob_id, bus.commit_value_to_reg); end
        tick();
        total++; if ({bus.commit_valid_to_reg, bus.commit_rd_to_reg, bus.commit_rob_id, bus.commit_value_to_reg} !== {1'b1, 5'd6, 4'd2, 32'h20}) begin bad++; $display("FAIL order_c2 got v=%0b rd=%0d id=%0d val=%0h exp v=1 rd=6 id=2 val=20", bus.commit_valid_to_reg, bus.commit_rd_to_reg, bus.commit_rob_id, bus.commit_value_to_reg); end
        tick();
        total++; if ({bus.commit_valid_to_reg, bus.commit_rd_to_reg, bus.commit_rob_id, bus.commit_value_to_reg} !== {1'b1, 5'd7, 4'd3, 32'h30}) begin bad++; $display("FAIL order_c3 got v=%0b rd=%0d id=%0d val=%0h exp v=1 rd=7 id=3 val=30", bus.commit_valid_to_reg, bus.commit_rd_to_reg, bus.commit_rob_id, bus.commit_value_to_reg); end
        tick();
        total++; if (bus.commit_valid_to_reg !== 1'b0) begin bad++; $display("FAIL order_drained got=%0b exp=0", bus.commit_valid_to_reg); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 1; i <= 15; i++) begin
            if (i == 15) begin
                total++; if (bus.full_to_if !== 1'b0) begin bad++; $display("FAIL full_before_last got=%0b exp=0", bus.full_to_if); end
            end
            alloc(5'(i), 1'b0);
        end
        total++; if (bus.full_to_if !== 1'b1) begin bad++; $display("FAIL full_after15 got=%0b exp=1", bus.full_to_if); end
        total++; if (bus.rob_id_to_dsp !== 4'd1) begin bad++; $display("FAIL full_tail_wrap got=%0h exp=1", bus.rob_id_to_dsp); end
        bus.ena_from_dsp = 1'b1;
        bus.rd_from_dsp  = 5'd20;
        rs_cdb(4'd1, 32'h77);
        tick();
        total++; if ({bus.full_to_if, bus.rob_id_to_dsp} !== {1'b1, 4'd1}) begin bad++; $display("FAIL full_16th_refused got full=%0b id=%0h exp full=1 id=1", bus.full_to_if, bus.rob_id_to_dsp); end
        bus.valid_from_rs_cdb = 1'b0;
        tick();
        total++; if ({bus.commit_valid_to_reg, bus.commit_rob_id, bus.commit_value_to_reg} !== {1'b1, 4'd1, 32'h77}) begin bad++; $display("FAIL full_commit1 got v=%0b id=%0h val=%0h exp v=1 id=1 val=77", bus.commit_valid_to_reg, bus.commit_rob_id, bus.commit_value_to_reg); end
        total++; if ({bus.full_to_if, bus.rob_id_to_dsp} !== {1'b0, 4'd1}) begin bad++; $display("FAIL full_refused_during_commit got full=%0b id=%0h exp full=0 id=1", bus.full_to_if, bus.rob_id_to_dsp); end
        bus.rd_from_dsp = 5'd21;
        tick();
        bus.ena_from_dsp = 1'b0;
        total++; if ({bus.full_to_if, bus.rob_id_to_dsp} !== {1'b1, 4'd2}) begin bad++; $display("FAIL full_realloc_id1 got full=%0b id=%0h exp full=1 id=2", bus.full_to_if, bus.rob_id_to_dsp); end
    endtask

    task automatic test_query();
        do_reset();
        for (int i = 1; i <= 4; i++) alloc(5'(i), 1'b0);
        bus.Q1_query = 4'd4;
        bus.Q2_query = 4'd0;
        rs_cdb(4'd4, 32'hAB);
        #1;
        total++; if ({bus.Q1_ready, bus.V1_query} !== {1'b1, 32'hAB}) begin bad++; $display("FAIL query_rs_bypass got r=%0b v=%0h exp r=1 v=ab", bus.Q1_ready, bus.V1_query); end
        total++; if ({bus.Q2_ready, bus.V2_query} !== {1'b1, 32'h0}) begin bad++; $display("FAIL query_zero got r=%0b v=%0h exp r=1 v=0", bus.Q2_ready, bus.V2_query); end
        bus.Q2_query           = 4'd4;
        bus.valid_from_ls_cdb  = 1'b1;
        bus.rob_id_from_ls_cdb = 4'd4;
        bus.result_from_ls_cdb = 32'hCD;
        #1;
        total++; if ({bus.Q2_ready, bus.V2_query} !== {1'b1, 32'hAB}) begin bad++; $display("FAIL query_rs_priority got r=%0b v=%0h exp r=1 v=ab", bus.Q2_ready, bus.V2_query); end
        bus.Q2_query           = 4'd3;
        bus.rob_id_from_ls_cdb = 4'd3;
        bus.result_from_ls_cdb = 32'h33;
        bus.Q1_query           = 4'd2;
        #1;
        total++; if ({bus.Q2_ready, bus.V2_query} !== {1'b1, 32'h33}) begin bad++; $display("FAIL query_ls_bypass got r=%0b v=%0h exp r=1 v=33", bus.Q2_ready, bus.V2_query); end
        total++; if (bus.Q1_ready !== 1'b0) begin bad++; $display("FAIL query_pending got r=%0b exp r=0", bus.Q1_ready); end
        tick();
        bus.valid_from_ls_cdb = 1'b0;
        rs_cdb(4'd9, 32'h99);
        tick();
        bus.valid_from_rs_cdb = 1'b0;
        bus.Q1_query = 4'd4;
        bus.Q2_query = 4'd9;
        #1;
        total++; if ({bus.Q1_ready, bus.V1_query} !== {1'b1, 32'hAB}) begin bad++; $display("FAIL query_stored got r=%0b v=%0h exp r=1 v=ab", bus.Q1_ready, bus.V1_query); end
        total++; if (bus.Q2_ready !== 1'b0) begin bad++; $display("FAIL query_nonbusy_ignored got r=%0b exp r=0", bus.Q2_ready); end
        bus.Q1_query = 4'd3;
        #1;
        total++; if ({bus.Q1_ready, bus.V1_query} !== {1'b1, 32'h33}) begin bad++; $display("FAIL query_stored_ls got r=%0b v=%0h exp r=1 v=33", bus.Q1_ready, bus.V1_query); end
        idle();
    endtask

    task automatic test_store();
        do_reset();
        alloc(5'd8, 1'b1);
        alloc(5'd0, 1'b0);
        bus.valid_from_ls_cdb  = 1'b1;
        bus.rob_id_from_ls_cdb = 4'd1;
        bus.result_from_ls_cdb = 32'h44;
        tick();
        bus.valid_from_ls_cdb = 1'b0;
        rs_cdb(4'd2, 32'h55);
        tick();
        bus.valid_from_rs_cdb = 1'b0;
        total++; if ({bus.commit_store_to_lsb, bus.commit_valid_to_reg, bus.commit_rob_id} !== {1'b1, 1'b0, 4'd1}) begin bad++; $display("FAIL store_commit got st=%0b v=%0b id=%0h exp st=1 v=0 id=1", bus.commit_store_to_lsb, bus.commit_valid_to_reg, bus.commit_rob_id); end
        tick();
        total++; if ({bus.commit_store_to_lsb, bus.commit_valid_to_reg, bus.commit_rob_id} !== {1'b0, 1'b0, 4'd2}) begin bad++; $display("FAIL rd0_commit got st=%0b v=%0b id=%0h exp st=0 v=0 id=2", bus.commit_store_to_lsb, bus.commit_valid_to_reg, bus.commit_rob_id); end
    endtask

    task automatic test_mispredict();
        do_reset();
        alloc(5'd1, 1'b0);
        alloc(5'd3, 1'b0);
        alloc(5'd4, 1'b0);
        rs_cdb(4'd1, 32'h11);
        bus.valid_from_ls_cdb  = 1'b1;
        bus.rob_id_from_ls_cdb = 4'd3;
        bus.result_from_ls_cdb = 32'h33;
        tick();
        bus.valid_from_ls_cdb      = 1'b0;
        rs_cdb(4'd2, 32'h8);
        bus.mispredict_from_rs_cdb = 1'b1;
        bus.target_pc_from_rs_cdb  = 32'h1000;
        tick();
        idle();
        total++; if ({bus.commit_valid_to_reg, bus.commit_rob_id, bus.commit_jump_flag} !== {1'b1, 4'd1, 1'b0}) begin bad++; $display("FAIL br_pre_commit got v=%0b id=%0h j=%0b exp v=1 id=1 j=0", bus.commit_valid_to_reg, bus.commit_rob_id, bus.commit_jump_flag); end
        tick();
        total++; if ({bus.commit_jump_flag, bus.target_pc_to_if} !== {1'b1, 32'h1000}) begin bad++; $display("FAIL br_jump got j=%0b tgt=%0h exp j=1 tgt=1000", bus.commit_jump_flag, bus.target_pc_to_if); end
        total++; if ({bus.commit_valid_to_reg, bus.commit_rd_to_reg, bus.commit_value_to_reg, bus.commit_rob_id} !== {1'b1, 5'd3, 32'h8, 4'd2}) begin bad++; $display("FAIL br_link got v=%0b rd=%0d val=%0h id=%0h exp v=1 rd=3 val=8 id=2", bus.commit_valid_to_reg, bus.commit_rd_to_reg, bus.commit_value_to_reg, bus.commit_rob_id); end
        bus.ena_from_dsp = 1'b1;
        bus.rd_from_dsp  = 5'd9;
        tick();
        bus.ena_from_dsp = 1'b0;
        total++; if ({bus.commit_jump_flag, bus.target_pc_to_if, bus.commit_valid_to_reg} !== {1'b0, 32'h0, 1'b0}) begin bad++; $display("FAIL br_one_cycle got j=%0b tgt=%0h v=%0b exp j=0 tgt=0 v=0", bus.commit_jump_flag, bus.target_pc_to_if, bus.commit_valid_to_reg); end
        total++; if ({bus.rob_id_to_dsp, bus.full_to_if} !== {4'd1, 1'b0}) begin bad++; $display("FAIL br_flushed got id=%0h full=%0b exp id=1 full=0", bus.rob_id_to_dsp, bus.full_to_if); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (bus.commit_valid_to_reg !== 1'b0) begin bad++; $display("FAIL br_no_stale_commit cycle=%0d got v=%0b id=%0h exp v=0", i, bus.commit_valid_to_reg, bus.commit_rob_id); end
        end
    endtask

    task automatic test_rdy_hold();
        do_reset();
        alloc(5'd2, 1'b0);
        rs_cdb(4'd1, 32'h5A);
        tick();
        bus.valid_from_rs_cdb = 1'b0;
        rdy = 1'b0;
        bus.ena_from_dsp = 1'b1;
        bus.rd_from_dsp  = 5'd3;
        tick();
        tick();
        total++; if ({bus.commit_valid_to_reg, bus.rob_id_to_dsp} !== {1'b0, 4'd2}) begin bad++; $display("FAIL rdy_hold got v=%0b id=%0h exp v=0 id=2", bus.commit_valid_to_reg, bus.rob_id_to_dsp); end
        bus.ena_from_dsp = 1'b0;
        rdy = 1'b1;
        tick();
        total++; if ({bus.commit_valid_to_reg, bus.commit_value_to_reg, bus.commit_rob_id} !== {1'b1, 32'h5A, 4'd1}) begin bad++; $display("FAIL rdy_resume got v=%0b val=%0h id=%0h exp v=1 val=5a id=1", bus.commit_valid_to_reg, bus.commit_value_to_reg, bus.commit_rob_id); end
    endtask

    task automatic test_async_reset();
        do_reset();
        alloc(5'd9, 1'b0);
        alloc(5'd10, 1'b0);
        rs_cdb(4'd1, 32'hEE);
        tick();
        bus.valid_from_rs_cdb = 1'b0;
        tick();
        total++; if ({bus.commit_valid_to_reg, bus.commit_rob_id} !== {1'b1, 4'd1}) begin bad++; $display("FAIL ar_precommit got v=%0b id=%0h exp v=1 id=1", bus.commit_valid_to_reg, bus.commit_rob_id); end
        #2;
        rst = 1'b1;
        #1;
        total++; if ({bus.commit_valid_to_reg, bus.commit_rd_to_reg, bus.commit_value_to_reg, bus.commit_rob_id} !== '0) begin bad++; $display("FAIL ar_outputs got v=%0b rd=%0d val=%0h id=%0h exp 0", bus.commit_valid_to_reg, bus.commit_rd_to_reg, bus.commit_value_to_reg, bus.commit_rob_id); end
        total++; if ({bus.rob_id_to_dsp, bus.full_to_if} !== {4'd1, 1'b0}) begin bad++; $display("FAIL ar_pointers got id=%0h full=%0b exp id=1 full=0", bus.rob_id_to_dsp, bus.full_to_if); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        alloc(5'd12, 1'b0);
        rs_cdb(4'd1, 32'h12);
        tick();
        bus.valid_from_rs_cdb = 1'b0;
        tick();
        total++; if ({bus.commit_valid_to_reg, bus.commit_rob_id, bus.commit_rd_to_reg} !== {1'b1, 4'd1, 5'd12}) begin bad++; $display("FAIL ar_head_reset got v=%0b id=%0h rd=%0d exp v=1 id=1 rd=12", bus.commit_valid_to_reg, bus.commit_rob_id, bus.commit_rd_to_reg); end
    endtask

    initial begin
        idle();
        test_reset();
        test_alloc();
        test_in_order_commit();
        test_full_wrap();
        test_query();
        test_store();
        test_mispredict();
        test_rdy_hold();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
